// File: rtl/mpp_pkg.sv
// Shared definitions for the mpp program memory.
//   INSTR_W    : instruction byte width
//   PADDR_W    : core program address width
//   ld_state_e : loader frame state
//   frame_len  : expands the LEN header byte into the number of data bytes
package mpp_pkg;

    localparam int INSTR_W = 8;
    localparam int PADDR_W = 16;

    typedef enum logic [2:0] {
        L_HDR,
        L_ADDR_LO,
        L_LEN,
        L_DATA,
        L_CHK,
        L_DONE
    } ld_state_e;

    // A LEN byte of zero stands for a full 256-byte payload.
    function automatic logic [8:0] frame_len(input logic [7:0] len_byte);
        return (len_byte == 8'h00) ? 9'd256 : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/mpp_prog_mem_if.sv
// Bus bundle between the core/loader side (master) and the program memory (slave).
//   program_addr / program_rd        : core instruction fetch request
//   instruction / instr_valid        : registered fetch response
//   cpu_hold                         : core must stall while a frame loads
//   ld_data / ld_valid / ld_ready    : loader byte stream handshake
//   load_done / load_err             : frame completion pulse, sticky checksum error
interface mpp_prog_mem_if;
    import mpp_pkg::*;

    logic [PADDR_W-1:0] program_addr;
    logic               program_rd;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic               cpu_hold;
    logic [7:0]         ld_data;
    logic               ld_valid;
    logic               ld_ready;
    logic               load_done;
    logic               load_err;

    modport master (
        output program_addr, program_rd, ld_data, ld_valid,
        input  instruction, instr_valid, cpu_hold, ld_ready, load_done, load_err
    );

    modport slave (
        input  program_addr, program_rd, ld_data, ld_valid,
        output instruction, instr_valid, cpu_hold, ld_ready, load_done, load_err
    );

endinterface

// File: rtl/mpp_prog_ram.sv
// Byte-wide program RAM: one synchronous write port and one registered read port.
//   clk, rst  : clock; rst clears only the read register, never the array
//   we_i      : write enable; waddr_i / wdata_i written on the rising edge
//   re_i      : read enable; rdata_o updated from raddr_i on the rising edge
module mpp_prog_ram #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mpp_prog_mem.sv
// Program memory for the mpp core: registered 1-cycle instruction fetch plus a
// byte-stream loader (ADDR_HI, ADDR_LO, LEN, data..., CHK) that writes programs.
//   clk  : single clock
//   rst  : synchronous active-high reset (memory array contents survive)
//   bus  : mpp_prog_mem_if.slave -- fetch port, loader handshake and status
module mpp_prog_mem import mpp_pkg::*; #(
    parameter int                 DEPTH_LOG2 = 8,
    parameter logic [INSTR_W-1:0] FILL       = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    mpp_prog_mem_if.slave  bus
);

    ld_state_e          state_q, state_d;
    logic [PADDR_W-1:0] addr_q, addr_d;
    logic [8:0]         cnt_q, cnt_d;
    logic [7:0]         sum_q, sum_d;
    logic               err_q, err_d;
    logic               rdy_en_q;
    logic               valid_q;
    logic               fill_q;

    logic                  ld_ready;
    logic                  accept;
    logic                  cpu_hold;
    logic                  rd_fire;
    logic                  in_range;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr;
    logic [INSTR_W-1:0]    ram_wdata;
    logic [INSTR_W-1:0]    ram_rdata;

    // Hold is a pure decode of the loader state: it rises the cycle after the
    // ADDR_HI byte is taken and falls once L_DONE has been spent, so reads
    // and loader writes can never share a cycle.
    assign cpu_hold = (state_q != L_HDR);

    // rdy_en_q keeps ready low through reset and for the edge that releases it.
    assign ld_ready = rdy_en_q && (state_q != L_DONE);
    assign accept   = bus.ld_valid && ld_ready;

    assign rd_fire  = bus.program_rd && !cpu_hold;
    assign in_range = ((bus.program_addr >> DEPTH_LOG2) == '0);

    mpp_prog_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (INSTR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (rd_fire && in_range),
        .raddr_i (bus.program_addr[DEPTH_LOG2-1:0]),
        .rdata_o (ram_rdata)
    );

    // Loader next-state and write strobe.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_waddr = addr_q[DEPTH_LOG2-1:0];
        ram_wdata = bus.ld_data;

        unique case (state_q)
            L_HDR: begin
                if (accept) begin
                    addr_d  = {bus.ld_data, addr_q[7:0]};
                    err_d   = 1'b0;
                    state_d = L_ADDR_LO;
                end
            end
            L_ADDR_LO: begin
                if (accept) begin
                    addr_d  = {addr_q[PADDR_W-1:8], bus.ld_data};
                    state_d = L_LEN;
                end
            end
            L_LEN: begin
                if (accept) begin
                    cnt_d   = frame_len(bus.ld_data);
                    sum_d   = 8'h00;
                    state_d = L_DATA;
                end
            end
            L_DATA: begin
                if (accept) begin
                    // Full 16-bit increment; only the low bits index the RAM,
                    // so a frame running past the top wraps to index 0.
                    ram_we = 1'b1;
                    addr_d = addr_q + PADDR_W'(1);
                    sum_d  = sum_q + bus.ld_data;
                    cnt_d  = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = L_CHK;
                    end
                end
            end
            L_CHK: begin
                if (accept) begin
                    if (bus.ld_data != sum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = L_DONE;
                end
            end
            L_DONE: begin
                state_d = L_HDR;
            end
            default: begin
                state_d = L_HDR;
            end
        endcase
    end

    // Control state: reset applies here only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= L_HDR;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
            valid_q  <= 1'b0;
            fill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
            valid_q  <= rd_fire;
            if (rd_fire) begin
                fill_q <= !in_range;
            end
        end
    end

    // Frame datapath: always written in the header states before it is used.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        cnt_q  <= cnt_d;
        sum_q  <= sum_d;
    end

    // Out-of-range fetches skip the RAM and substitute FILL via fill_q.
    assign bus.instruction = fill_q ? FILL : ram_rdata;
    assign bus.instr_valid = valid_q;
    assign bus.cpu_hold    = cpu_hold;
    assign bus.ld_ready    = ld_ready;
    assign bus.load_done   = (state_q == L_DONE);
    assign bus.load_err    = err_q;

endmodule
